// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, ID-branch operand stalls, taken-branch/jump flush, mul/div freeze.
// Optional build macro HAZARD_PERF_COUNTERS_EN adds stallCycles/flushCount/mdBusyCycles event counters.
//
//   state   | meaning
//   RUN     | normal issue; data stalls and control flushes evaluated each cycle
//   MD_BUSY | front end frozen while the multi-cycle mul/div unit works
module hazard_controller #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] registerRsID,
    input  logic [4:0] registerRtID,
    input  logic       usesRtID,
    input  logic       branchID,
    input  logic       branchTakenID,
    input  logic       jumpID,
    input  logic [4:0] registerRdEX,
    input  logic       regWriteEX,
    input  logic       memReadEX,
    input  logic [4:0] registerRdMEM,
    input  logic       memReadMEM,
    input  logic       mdStartEX,
    output logic       pcWrite,
    output logic       ifidWrite,
    output logic       ifidFlush,
    output logic       idexFlush,
    output logic       idexWrite,
    output logic       exmemBubble,
    output logic       mdBusy,
    output logic       mdDone
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    output logic [31:0] stallCycles,
    output logic [31:0] flushCount,
    output logic [31:0] mdBusyCycles
`endif
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } ctrlState;

    localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(MD_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    ctrlState         state;
    ctrlState         stateNext;
    logic [CNT_W-1:0] busyCount;
    logic [CNT_W-1:0] busyCountNext;

    logic rdExMatchRs;
    logic rdExMatchRt;
    logic rdMemMatchRs;
    logic rdMemMatchRt;
    logic loadUse;
    logic brEx;
    logic brMem;
    logic stall;
    logic redirect;

    // Register 0 is hard-wired zero, so it can never carry a dependency.
    assign rdExMatchRs  = (registerRdEX  != 5'd0) && (registerRdEX  == registerRsID);
    assign rdExMatchRt  = (registerRdEX  != 5'd0) && (registerRdEX  == registerRtID);
    assign rdMemMatchRs = (registerRdMEM != 5'd0) && (registerRdMEM == registerRsID);
    assign rdMemMatchRt = (registerRdMEM != 5'd0) && (registerRdMEM == registerRtID);

    assign loadUse  = memReadEX && (rdExMatchRs || (usesRtID && rdExMatchRt));
    assign brEx     = branchID && regWriteEX && (rdExMatchRs || rdExMatchRt);
    assign brMem    = branchID && memReadMEM && (rdMemMatchRs || rdMemMatchRt);
    assign stall    = loadUse || brEx || brMem;
    assign redirect = (branchID && branchTakenID) || jumpID;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RUN;
            busyCount <= '0;
        end else begin
            state     <= stateNext;
            busyCount <= busyCountNext;
        end
    end

    always_comb begin
        stateNext     = state;
        busyCountNext = busyCount;
        pcWrite       = 1'b1;
        ifidWrite     = 1'b1;
        ifidFlush     = 1'b0;
        idexFlush     = 1'b0;
        idexWrite     = 1'b1;
        exmemBubble   = 1'b0;
        mdBusy        = 1'b0;
        mdDone        = 1'b0;
        unique case (state)
            RUN: begin
                if (stall) begin
                    pcWrite   = 1'b0;
                    ifidWrite = 1'b0;
                    idexFlush = 1'b1;
                end else if (redirect) begin
                    ifidFlush = 1'b1;
                end
                if (mdStartEX) begin
                    stateNext     = MD_BUSY;
                    busyCountNext = BUSY_LOAD;
                end
            end
            MD_BUSY: begin
                pcWrite     = 1'b0;
                ifidWrite   = 1'b0;
                idexWrite   = 1'b0;
                exmemBubble = 1'b1;
                mdBusy      = 1'b1;
                if (busyCount == '0) begin
                    mdDone    = 1'b1;
                    stateNext = RUN;
                end else begin
                    busyCountNext = busyCount - CNT_ONE;
                end
            end
            default: stateNext = RUN;
        endcase
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stallCycles  <= '0;
            flushCount   <= '0;
            mdBusyCycles <= '0;
        end else begin
            if ((state == RUN) && stall) stallCycles <= stallCycles + 32'd1;
            if (ifidFlush) flushCount <= flushCount + 32'd1;
            if (mdBusy) mdBusyCycles <= mdBusyCycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: directed scenarios then random traffic against a cycle-level reference model.
module tb_hazard_controller;

    localparam int MD_LATENCY = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] registerRsID, registerRtID, registerRdEX, registerRdMEM;
    logic       usesRtID, branchID, branchTakenID, jumpID;
    logic       regWriteEX, memReadEX, memReadMEM, mdStartEX;
    logic       pcWrite, ifidWrite, ifidFlush, idexFlush, idexWrite;
    logic       exmemBubble, mdBusy, mdDone;
`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0] stallCycles, flushCount, mdBusyCycles;
    logic [95:0] perfQ[$];
`endif

    logic [7:0] expQ[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state: remaining freeze cycles plus event tallies.
    int          busyRem = 0;
    int unsigned pStall  = 0;
    int unsigned pFlush  = 0;
    int unsigned pBusy   = 0;

    hazard_controller #(.MD_LATENCY(MD_LATENCY), .CNT_W(4)) dut (
        .clock(clock), .reset(reset),
        .registerRsID(registerRsID), .registerRtID(registerRtID),
        .usesRtID(usesRtID), .branchID(branchID), .branchTakenID(branchTakenID),
        .jumpID(jumpID), .registerRdEX(registerRdEX), .regWriteEX(regWriteEX),
        .memReadEX(memReadEX), .registerRdMEM(registerRdMEM), .memReadMEM(memReadMEM),
        .mdStartEX(mdStartEX), .pcWrite(pcWrite), .ifidWrite(ifidWrite),
        .ifidFlush(ifidFlush), .idexFlush(idexFlush), .idexWrite(idexWrite),
        .exmemBubble(exmemBubble), .mdBusy(mdBusy), .mdDone(mdDone)
`ifdef HAZARD_PERF_COUNTERS_EN
        , .stallCycles(stallCycles), .flushCount(flushCount), .mdBusyCycles(mdBusyCycles)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic dep(input logic [4:0] producer, input logic [4:0] consumer);
        return (producer != 5'd0) && (producer == consumer);
    endfunction

    task automatic idle();
        reset = 0; registerRsID = 0; registerRtID = 0; usesRtID = 0; branchID = 0;
        branchTakenID = 0; jumpID = 0; registerRdEX = 0; regWriteEX = 0; memReadEX = 0;
        registerRdMEM = 0; memReadMEM = 0; mdStartEX = 0;
    endtask

    // Predict this cycle's outputs from the current inputs, queue them, advance the model, then move to the next cycle.
    task automatic step(input bit check);
        logic [7:0] e;
        logic stl, red, fl;
        stl = (memReadEX && (dep(registerRdEX, registerRsID) || (usesRtID && dep(registerRdEX, registerRtID))))
           || (branchID && regWriteEX && (dep(registerRdEX, registerRsID) || dep(registerRdEX, registerRtID)))
           || (branchID && memReadMEM && (dep(registerRdMEM, registerRsID) || dep(registerRdMEM, registerRtID)));
        red = (branchID && branchTakenID) || jumpID;
        fl  = 1'b0;
        // order: pcWrite ifidWrite ifidFlush idexFlush idexWrite exmemBubble mdBusy mdDone
        if (busyRem > 0)
            e = {6'b000001, 1'b1, busyRem == 1};
        else begin
            fl = !stl && red;
            e = {!stl, !stl, fl, stl, 1'b1, 3'b000};
        end
        if (check) begin
            expQ.push_back(e);
`ifdef HAZARD_PERF_COUNTERS_EN
            perfQ.push_back({pStall, pFlush, pBusy});
`endif
        end
        if (reset) begin
            busyRem = 0; pStall = 0; pFlush = 0; pBusy = 0;
        end else if (busyRem > 0) begin
            busyRem = busyRem - 1;
            pBusy   = pBusy + 1;
        end else begin
            if (stl) pStall = pStall + 1;
            if (fl) pFlush = pFlush + 1;
            if (mdStartEX) busyRem = MD_LATENCY;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    initial begin : monitor
        logic [7:0] want, got;
        forever begin
            @(negedge clock);
            if (expQ.size() > 0) begin
                want = expQ.pop_front();
                got  = {pcWrite, ifidWrite, ifidFlush, idexFlush, idexWrite, exmemBubble, mdBusy, mdDone};
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got=%b want=%b", cyc, got, want);
                end
`ifdef HAZARD_PERF_COUNTERS_EN
                begin
                    logic [95:0] pw;
                    pw = perfQ.pop_front();
                    total++;
                    if ({stallCycles, flushCount, mdBusyCycles} !== pw) begin
                        bad++;
                        $display("FAIL perf cyc=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", cyc,
                                 stallCycles, flushCount, mdBusyCycles, pw[95:64], pw[63:32], pw[31:0]);
                    end
                end
`endif
            end
        end
    end

    initial begin : stimulus
        int guard;
        idle();
        reset = 1;
        @(posedge clock);
        #1;
        step(0);
        idle();
        step(1);                                   // reset state defaults

        memReadEX = 1; registerRdEX = 8; registerRsID = 8;
        step(1);                                   // load-use stall
        idle();
        step(1);

        memReadEX = 1; registerRdEX = 0; registerRsID = 0;
        step(1);                                   // r0 never stalls
        idle();

        branchID = 1; registerRsID = 9; memReadEX = 1; registerRdEX = 9;
        step(1);
        memReadEX = 0; registerRdEX = 0; memReadMEM = 1; registerRdMEM = 9;
        step(1);
        memReadMEM = 0; registerRdMEM = 0; branchTakenID = 1;
        step(1);                                   // branch resolves, flush
        idle();

        jumpID = 1; memReadEX = 1; usesRtID = 1; registerRdEX = 5; registerRtID = 5;
        step(1);                                   // stall beats flush
        idle();

        mdStartEX = 1;
        step(1);                                   // T
        mdStartEX = 0; memReadEX = 1; registerRdEX = 7; registerRsID = 7;
        step(1);                                   // T+1
        mdStartEX = 1;
        step(1);                                   // T+2: ignored
        mdStartEX = 0;
        step(1);
        step(1);                                   // T+4: mdDone
        step(1);                                   // back in RUN, load-use visible
        idle();
        step(1);

        mdStartEX = 1;
        step(1);                                   // T
        mdStartEX = 0;
        step(1);
        reset = 1;
        step(1);                                   // reset at T+2
        reset = 0;
        step(1);
        step(1);
        step(1);

        for (int i = 0; i < 600; i++) begin
            registerRsID  = 5'($urandom_range(0, 3));
            registerRtID  = 5'($urandom_range(0, 3));
            registerRdEX  = 5'($urandom_range(0, 3));
            registerRdMEM = 5'($urandom_range(0, 3));
            usesRtID      = 1'($urandom_range(0, 1));
            branchID      = 1'($urandom_range(0, 1));
            branchTakenID = 1'($urandom_range(0, 1));
            jumpID        = ($urandom_range(0, 4) == 0);
            regWriteEX    = 1'($urandom_range(0, 1));
            memReadEX     = 1'($urandom_range(0, 1));
            memReadMEM    = 1'($urandom_range(0, 1));
            mdStartEX     = ($urandom_range(0, 9) == 0);
            reset         = ($urandom_range(0, 59) == 0);
            step(1);
        end
        idle();

        guard = 0;
        while (expQ.size() > 0 && guard < 10) begin
            @(negedge clock);
            guard++;
        end
        #1;
        if (expQ.size() > 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
